// File: rtl/input_pkg.sv
// Shared constants and helpers for the input-conditioning blocks.
package input_pkg;

  localparam int DEBOUNCE_STABLE_DEFAULT   = 4;
  localparam int DEBOUNCE_TICK_DIV_DEFAULT = 1;

  // The counter only has to reach stable-1, but stable+1 keeps stable=1 at a legal 1-bit width.
  function automatic int debounce_cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_lane.sv
// One debounce lane: two-flop synchroniser, qualification counter and level flop.
module debounce_lane
  import input_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic level
);

  localparam int CNT_W = debounce_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
  // synchroniser is truly two stages and the counter compares against last cycle's sync2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-lane push-button debouncer: entry inversion, shared sample-tick prescaler, per-lane filters.
module button_debounce
  import input_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT,
  parameter int TICK_DIV      = DEBOUNCE_TICK_DIV_DEFAULT,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  logic [WIDTH-1:0] x;
  logic             tick;

  assign x = (ACTIVE_LOW != 0) ? ~raw : raw;

  generate
    if (TICK_DIV == 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(TICK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
      logic [DIV_W-1:0] div;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          div <= '0;
        end else if (div == DIV_LAST) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign tick = (div == DIV_LAST);
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounce_lane #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .din    (x[i]),
      .level  (level[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: default instance (STABLE=4, DIV=1) plus a prescaled one (STABLE=2, DIV=3).
module tb_button_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] raw_a;
  logic [3:0] raw_b;
  logic [3:0] level_a;
  logic [3:0] level_b;

  int vectors;
  int miscompares;

  button_debounce #(
    .WIDTH(4), .STABLE_CYCLES(4), .TICK_DIV(1), .ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .raw(raw_a), .level(level_a)
  );

  button_debounce #(
    .WIDTH(4), .STABLE_CYCLES(2), .TICK_DIV(3), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .raw(raw_b), .level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rises;
    int rise_at;
    logic prev;

    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    raw_a       = 4'hF;
    raw_b       = 4'hF;

    // 1. Reset with idle (high) pins, then 50 quiet cycles.
    repeat (3) step();
    check("reset_hold_a", 32'(level_a), 32'h0);
    check("reset_hold_b", 32'(level_b), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_a", 32'(level_a), 32'h0);
    end
    check("idle_b", 32'(level_b), 32'h0);

    // 2. Clean press and release on lane 0: change at edge k+5 after first sampling at k.
    raw_a[0] = 1'b0;
    step();
    repeat (4) step();
    check("press_k4", 32'(level_a), 32'h0);
    step();
    check("press_k5", 32'(level_a), 32'h1);
    raw_a[0] = 1'b1;
    step();
    repeat (4) step();
    check("release_k4", 32'(level_a), 32'h1);
    step();
    check("release_k5", 32'(level_a), 32'h0);

    // 3. Lane 1: 3-cycle pulse is rejected, 4-cycle pulse is accepted.
    raw_a[1] = 1'b0;
    repeat (3) step();
    raw_a[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch3", 32'(level_a), 32'h0);
    end
    raw_a[1] = 1'b0;
    repeat (4) step();
    raw_a[1] = 1'b1;
    step();
    check("pulse4_k4", 32'(level_a), 32'h0);
    step();
    check("pulse4_k5", 32'(level_a), 32'h2);
    repeat (3) step();
    check("pulse4_k8", 32'(level_a), 32'h2);
    step();
    check("pulse4_k9", 32'(level_a), 32'h0);

    // 4. Lane 2 bounces every cycle for 20 cycles, then settles active.
    rises = 0;
    prev  = level_a[2];
    for (int i = 0; i < 20; i++) begin
      raw_a[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      check("bounce", 32'(level_a[2]), 32'h0);
    end
    raw_a[2] = 1'b0;
    step();
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) check("bounce_k4", 32'(level_a), 32'h0);
      if (i == 5) check("bounce_k5", 32'(level_a), 32'h4);
      if (level_a[2] && !prev) rises++;
      prev = level_a[2];
    end
    check("bounce_rises", 32'(rises), 32'd1);

    // 5. Prescaled instance: lane 0 rises within [k+5, k+7]; lane 3 and others stay idle.
    raw_b[0] = 1'b0;
    step();
    rise_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (level_b[0] && rise_at < 0) rise_at = i;
    end
    check("div_rise_window", 32'((rise_at >= 5) && (rise_at <= 7)), 32'h1);
    check("div_other_lanes", 32'(level_b), 32'h1);

    // 6. Reset mid-count on lane 0 (lane 2 is still high and must clear too).
    raw_a[0] = 1'b0;
    step();
    repeat (3) step();
    check("pre_reset", 32'(level_a), 32'h4);
    reset_n = 1'b0;
    #1;
    check("async_reset_a", 32'(level_a), 32'h0);
    check("async_reset_b", 32'(level_b), 32'h0);
    raw_a[2] = 1'b1;
    step();
    step();
    check("reset_held", 32'(level_a), 32'h0);
    reset_n = 1'b1;
    step();
    repeat (4) step();
    check("post_reset_k4", 32'(level_a), 32'h0);
    step();
    check("post_reset_k5", 32'(level_a), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
